scan_selector: RTL
==================

SCAN_SELECTOR -- requirements
Module: scan_selector

Interface
REQ-001 SHALL have parameter N, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter W, default 4: channel data width, 1..32.
REQ-003 SHALL have parameter DWELL, default 4: cycles spent on each channel in auto-scan, 1..65535.
REQ-004 SHALL have localparam SW = max(1, clog2(N)): channel index width.
REQ-005 SHALL have port iClk  in  1  the single clock; all state changes on rising edge.
REQ-006 SHALL have port iRst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port iData  in  N*W  packed channels; channel k occupies bits [k*W +: W].
REQ-008 SHALL have port iMode  in  1  0 = manual select, 1 = auto-scan.
REQ-009 SHALL have port iSel  in  SW  manual channel index.
REQ-010 SHALL have port iHold  in  1  freezes auto-scan while high.
REQ-011 SHALL have port oZ  out  W  registered data of the selected channel.
REQ-012 SHALL have port oCh  out  SW  registered index of the selected channel.
REQ-013 SHALL have port oStep  out  1  one-cycle pulse on each auto-scan channel advance.

Function
REQ-014 SHALL implement states MANUAL, SCAN and PAUSE, re-evaluated every cycle: iMode=0 -> MANUAL; iMode=1 with iHold=0 -> SCAN; iMode=1 with iHold=1 -> PAUSE.
REQ-015 SHALL, in MANUAL, load oCh <= iSel every cycle; an iSel >= N SHALL leave oCh unchanged.
REQ-016 SHALL, in SCAN, increment the dwell counter each cycle; when the counter equals DWELL-1 it SHALL clear, advance oCh to the next enabled channel (N-1 wraps to 0) and pulse oStep for that cycle.
REQ-017 SHALL, on entry to SCAN from MANUAL, start scanning from the current oCh with the dwell counter cleared.
REQ-018 SHALL, in PAUSE, freeze oCh and the dwell counter; leaving PAUSE for SCAN SHALL resume the count without clearing it.
REQ-019 SHALL update oZ on the same edge as oCh, with oZ = iData slice of the new oCh index; latency from iSel or iData to oZ is one cycle.
REQ-020 SHALL keep oStep low in MANUAL and PAUSE; DWELL=1 SHALL advance every cycle with oStep held high.
REQ-021 SHALL take the mode change when iMode and iHold change in the same cycle as a dwell expiry; no advance SHALL occur unless the next state is SCAN.

Reset
REQ-022 SHALL, while iRst=1 at a rising edge, set oZ=0, oCh=0, oStep=0, dwell counter=0 and state MANUAL.
REQ-023 SHALL give reset priority over every other input, including during SCAN.

Configuration
REQ-024 SHALL, with macro SCAN_SEL_MASK_EN defined, add input iMask (N bits, 1 = channel enabled).
REQ-025 SHALL, with SCAN_SEL_MASK_EN, make auto-scan skip disabled channels and select the next enabled index modulo N.
REQ-026 SHALL, with SCAN_SEL_MASK_EN and all channels disabled, hold oCh and keep oStep low.
REQ-027 SHALL, with SCAN_SEL_MASK_EN, force oZ=0 when a disabled channel is selected in MANUAL.
REQ-028 SHALL, without SCAN_SEL_MASK_EN, have no iMask port and treat every channel as enabled.

Structure
REQ-029 SHALL place the state encoding (MANUAL/SCAN/PAUSE) and the mode constants (MODE_MANUAL=0, MODE_SCAN=1) in shared package sel_pkg.
REQ-030 SHALL implement the dwell counter as sub-module sel_dwell_cnt, with inputs clear/enable and output expire.

Verification (N=4, W=4, DWELL=4, iData = {1111, 0101, 0010, 0000})
REQ-031 SHALL cover: iRst=1 for 2 cycles -> oZ=0000, oCh=0, oStep=0.
REQ-032 SHALL cover: MANUAL with iSel stepped 0,1,2,3 -> oZ = 0000, 0010, 0101, 1111, each one cycle after iSel.
REQ-033 SHALL cover: iMode=1 from oCh=0 -> oCh 0->1->2->3->0 every 4 cycles, with a single-cycle oStep at each advance.
REQ-034 SHALL cover: iHold=1 for 10 cycles mid-dwell -> oCh, counter and oZ frozen; after release the advance occurs after the remaining dwell cycles only.
REQ-035 SHALL cover: iRst=1 during SCAN at oCh=2 -> next cycle oCh=0, oZ=0000, state MANUAL.
REQ-036 SHALL cover, with SCAN_SEL_MASK_EN and iMask=1010: scan visits 1,3,1,3 with oZ 0010, 1111; with iMask=0000, oCh is held and oStep never pulses.

Source files
------------

// File: rtl/sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sel_pkg
//  Description : Shared state encoding, mode constants and index-width helper
//                for the scan selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package sel_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        PAUSE  = 2'd2
    } sel_state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sel_dwell_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sel_dwell_cnt
//  Description : Dwell counter; counts enabled cycles and flags the cycle in
//                which the count reaches DWELL-1, then wraps to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sel_dwell_cnt
    import sel_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic iClk,
    input  logic iRst,
    input  logic iClear,
    input  logic iEnable,
    output logic oExpire
);

    localparam int CW = idx_width(DWELL);

    logic [CW-1:0] r_cnt_q;
    logic [CW-1:0] w_cnt_d;
    logic [CW-1:0] w_cnt_eff;
    logic          w_expire;

    // A clear takes effect in the same cycle, so a cleared counter can count.
    always_comb begin
        w_cnt_eff = iClear ? '0 : r_cnt_q;
        w_expire  = iEnable && (w_cnt_eff == CW'(DWELL - 1));
        w_cnt_d   = w_cnt_eff;
        if (iEnable) begin
            w_cnt_d = w_expire ? '0 : (w_cnt_eff + CW'(1));
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign oExpire = w_expire;

endmodule
`default_nettype wire

// File: rtl/scan_selector.sv
`default_nettype none
// ============================================================================
//  Module      : scan_selector
//  Description : N-channel selector with manual select and auto-scan modes.
//                Optional macro SCAN_SEL_MASK_EN adds a channel-enable mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_selector
    import sel_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 4,
    parameter  int DWELL = 4,
    localparam int SW    = idx_width(N)
) (
    input  logic           iClk,
    input  logic           iRst,
    input  logic [N*W-1:0] iData,
    input  logic           iMode,
    input  logic [SW-1:0]  iSel,
    input  logic           iHold,
`ifdef SCAN_SEL_MASK_EN
    input  logic [N-1:0]   iMask,
`endif
    output logic [W-1:0]   oZ,
    output logic [SW-1:0]  oCh,
    output logic           oStep
);

    sel_state_e    r_state_q;
    sel_state_e    w_state_d;
    logic [SW-1:0] r_ch_q;
    logic [SW-1:0] w_ch_d;
    logic [W-1:0]  r_z_q;
    logic [W-1:0]  w_z_d;
    logic          r_step_q;
    logic          w_step_d;

    logic [N-1:0]  w_en;
    logic [SW-1:0] w_next_ch;
    logic          w_next_ok;
    logic          w_ch_en;
    logic          w_sel_ok;
    logic          w_expire;

`ifdef SCAN_SEL_MASK_EN
    assign w_en = iMask;
`else
    assign w_en = '1;
`endif

    always_comb begin
        if (iMode == MODE_MANUAL) begin
            w_state_d = MANUAL;
        end else if (iHold) begin
            w_state_d = PAUSE;
        end else begin
            w_state_d = SCAN;
        end
    end

    // The first cycle after MANUAL starts the dwell from zero.
    sel_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .iClk    (iClk),
        .iRst    (iRst),
        .iClear  (r_state_q == MANUAL),
        .iEnable (w_state_d == SCAN),
        .oExpire (w_expire)
    );

    // Nearest enabled channel above the current one, modulo N.
    always_comb begin
        w_next_ch = r_ch_q;
        w_next_ok = 1'b0;
        for (int k = N; k >= 1; k--) begin
            for (int j = 0; j < N; j++) begin
                if ((j == (int'(r_ch_q) + k) % N) && w_en[j]) begin
                    w_next_ch = SW'(j);
                    w_next_ok = 1'b1;
                end
            end
        end
    end

    assign w_sel_ok = ({{(32-SW){1'b0}}, iSel} < 32'(N));

    always_comb begin
        w_ch_d   = r_ch_q;
        w_step_d = 1'b0;
        case (w_state_d)
            MANUAL: begin
                if (w_sel_ok) begin
                    w_ch_d = iSel;
                end
            end
            SCAN: begin
                if (w_expire && w_next_ok) begin
                    w_ch_d   = w_next_ch;
                    w_step_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        w_z_d   = '0;
        w_ch_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (w_ch_d == SW'(k)) begin
                w_z_d   = iData[k*W +: W];
                w_ch_en = w_en[k];
            end
        end
        if ((w_state_d == MANUAL) && !w_ch_en) begin
            w_z_d = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state_q <= MANUAL;
            r_ch_q    <= '0;
            r_z_q     <= '0;
            r_step_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ch_q    <= w_ch_d;
            r_z_q     <= w_z_d;
            r_step_q  <= w_step_d;
        end
    end

    assign oZ    = r_z_q;
    assign oCh   = r_ch_q;
    assign oStep = r_step_q;

endmodule
`default_nettype wire
